// File: rtl/commit_arbiter.sv
// ---------------------------------------------------------------------------
// commit_arbiter
//
// Merges NUM_INPUTS commit streams (ALU, LSU, FPU, SFU, ...) into a single
// commit stream toward writeback / scoreboard release.
//
// Arbitration is round-robin with a packet lock. A multi-beat commit (sop..eop)
// from one requester is never interleaved with beats from another requester.
// The merged stream is registered through a 2-entry skid buffer. As a result,
// out_ready has no combinational path to in_ready.
//
// Beat layout: bit 0 = eop, bit 1 = sop. All other bits pass through untouched.
//
// Optional feature, enabled by defining COMMIT_ARBITER_PERF_EN:
//   This adds parameter PERF_CTR_BITS and output perf_stall_cycles.
//   perf_stall_cycles counts the cycles in which some requester is valid but
//   no input beat is accepted. The count wraps on overflow.
//
// Ports:
//   clk                clock
//   reset              synchronous active-high reset
//   in_valid  [N]      per-requester beat valid
//   in_data   [N*DW]   requester i occupies bits [i*DW +: DW]
//   in_ready  [N]      per-requester accept
//   out_valid          merged commit valid
//   out_data  [DW]     merged commit beat, unmodified
//   out_ready          downstream accept
//   out_sel   [SEL_W]  index of the requester that produced out_data
//   perf_stall_cycles  stall counter (COMMIT_ARBITER_PERF_EN only)
// ---------------------------------------------------------------------------
module commit_arbiter #(
  parameter int NUM_INPUTS    = 4,
  parameter int DATA_WIDTH    = 128,
`ifdef COMMIT_ARBITER_PERF_EN
  parameter int PERF_CTR_BITS = 44,
`endif
  localparam int SEL_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic                             out_valid,
  output logic [DATA_WIDTH-1:0]            out_data,
  input  logic                             out_ready,
`ifdef COMMIT_ARBITER_PERF_EN
  output logic [PERF_CTR_BITS-1:0]         perf_stall_cycles,
`endif
  output logic [SEL_W-1:0]                 out_sel
);

  typedef enum logic {S_OPEN, S_LOCKED} lock_state_t;

  lock_state_t           state_q, state_d;
  logic [SEL_W-1:0]      owner_q;
  logic [SEL_W-1:0]      rr_q;
  logic [SEL_W-1:0]      grant_idx;
  logic [SEL_W-1:0]      cand;
  logic                  grant_found;
  logic                  has_space_q;
  logic                  in_fire;
  logic                  out_fire;
  logic [DATA_WIDTH-1:0] in_beats [NUM_INPUTS];
  logic [DATA_WIDTH-1:0] beat;

  // Skid buffer: a 2-entry circular store. The head entry drives the output.
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic [SEL_W-1:0]      buf_sel  [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q, count_d;

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      in_beats[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // ---- lock FSM: state register ----
  // NOTE: clocked state is written with non-blocking assignments only.
  // This keeps every flop reading the pre-edge values of the other flops.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_OPEN;
    else       state_q <= state_d;
  end

  // ---- lock FSM: next state ----
  // While locked, only the owner can fire, so an accepted eop always comes
  // from the owner and releases the lock.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch.
    // Without the default, a path that skips the assignment would infer a latch.
    state_d = state_q;
    if (in_fire) state_d = beat[0] ? S_OPEN : S_LOCKED;
  end

  // ---- lock FSM: outputs (grant / accept) ----
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    cand        = '0;
    if (state_q == S_LOCKED) begin
      grant_idx   = owner_q;
      grant_found = in_valid[owner_q];
    end else begin
      // Scan downward so the requester closest to the pointer wins last.
      for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
        cand = SEL_W'((int'(rr_q) + k) % NUM_INPUTS);
        if (in_valid[cand]) begin
          grant_idx   = cand;
          grant_found = 1'b1;
        end
      end
    end
    // Acceptance is suppressed while reset is asserted. Any beat written in
    // that cycle would be discarded, so upstream must not treat it as taken.
    in_fire             = grant_found & has_space_q & ~reset;
    in_ready            = '0;
    in_ready[grant_idx] = in_fire;
  end

  assign beat      = in_beats[grant_idx];
  assign out_valid = (count_q != 2'd0);
  assign out_fire  = out_valid & out_ready;
  assign out_data  = buf_data[rd_ptr_q];
  assign out_sel   = buf_sel[rd_ptr_q];

  assign count_d = count_q + {1'b0, in_fire} - {1'b0, out_fire};

  // ---- datapath, pointer and skid buffer ----
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= 2'd0;
      has_space_q <= 1'b1;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      rr_q        <= '0;
      owner_q     <= '0;
      // NOTE: the two storage entries are reset on purpose.
      // out_data and out_sel must read zero after reset.
      // The storage is only two entries, so clearing it is cheap.
      for (int e = 0; e < 2; e++) begin
        buf_data[e] <= '0;
        buf_sel[e]  <= '0;
      end
    end else begin
      count_q <= count_d;
      // Space is registered from the next occupancy. This keeps out_ready off
      // the in_ready path while still allowing simultaneous push and pop at
      // occupancy 1.
      has_space_q <= (count_d != 2'd2);
      if (in_fire) begin
        buf_data[wr_ptr_q] <= beat;
        buf_sel[wr_ptr_q]  <= grant_idx;
        wr_ptr_q           <= ~wr_ptr_q;
        if (!beat[0]) begin
          owner_q <= grant_idx;
        end else begin
          rr_q <= (int'(grant_idx) == NUM_INPUTS - 1) ? '0 : grant_idx + 1'b1;
        end
      end
      if (out_fire) rd_ptr_q <= ~rd_ptr_q;
    end
  end

`ifdef COMMIT_ARBITER_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) perf_stall_cycles <= '0;
    else if ((|in_valid) && !in_fire) perf_stall_cycles <= perf_stall_cycles + 1'b1;
  end
`else
  // No stall accounting in this build.
`endif

endmodule
